// File: rtl/acc_pkg.sv
// Shared constants and FSM encoding for the accumulator readout block.
package acc_pkg;

  localparam int ACC_SIZE    = 8;
  localparam int ACC_DEPTH   = 8;
  localparam int ACC_PSW     = 8 + 4 + 4 + $clog2(ACC_SIZE);
  localparam int ACC_OUT_W   = 8;
  localparam int ACC_ADDR_W  = 3;
  localparam int ACC_SHIFT_W = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } acc_state_t;

endpackage

// File: rtl/acc_rd_postproc.sv
// Combinational quantizer: arithmetic shift with round-half-up, optional ReLU,
// then saturation to the signed output range.
module acc_rd_postproc
  import acc_pkg::*;
#(
  parameter int PSW   = ACC_PSW,
  parameter int OUT_W = ACC_OUT_W
) (
  input  logic signed [PSW-1:0]         din,
  input  logic        [ACC_SHIFT_W-1:0] shift_amt,
  input  logic                          relu_en,
  output logic signed [OUT_W-1:0]       dout
);

  // One guard bit above the input so the rounding increment cannot wrap.
  localparam logic signed [PSW:0] SAT_HI = {{(PSW - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [PSW:0] SAT_LO = {{(PSW - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};

  function automatic logic signed [PSW:0] shift_round(
    input logic signed [PSW-1:0]         x,
    input logic        [ACC_SHIFT_W-1:0] sh
  );
    logic signed [PSW:0] ext;
    logic signed [PSW:0] quo;
    logic signed [PSW:0] pre;
    logic                rbit;
    ext  = {x[PSW-1], x};
    quo  = ext >>> sh;
    // Bit sh-1 of the input is the first bit shifted out; it carries the half-LSB.
    pre  = ext >>> (sh - 5'd1);
    rbit = (sh != '0) && pre[0];
    return quo + {{PSW{1'b0}}, rbit};
  endfunction

  function automatic logic signed [OUT_W-1:0] saturate(input logic signed [PSW:0] v);
    if (v > SAT_HI)
      return SAT_HI[OUT_W-1:0];
    else if (v < SAT_LO)
      return SAT_LO[OUT_W-1:0];
    else
      return v[OUT_W-1:0];
  endfunction

  logic signed [PSW:0] rnd_v;
  logic signed [PSW:0] rel_v;

  // Shift/round, clamp negatives when ReLU is on, then saturate.
  always_comb begin
    rnd_v = shift_round(din, shift_amt);
    rel_v = (relu_en && (rnd_v < 0)) ? '0 : rnd_v;
    dout  = saturate(rel_v);
  end

endmodule

// File: rtl/acc_readout.sv
// Drains DEPTH accumulator entries in address order, quantizes each word and
// hands it downstream through a 2-entry valid/ready FIFO.
module acc_readout
  import acc_pkg::*;
#(
  parameter int SIZE              = ACC_SIZE,
  parameter int DEPTH             = ACC_DEPTH,
  parameter int PARTIAL_SUM_WIDTH = 8 + 4 + 4 + $clog2(SIZE),
  parameter int OUT_WIDTH         = ACC_OUT_W
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic        [ACC_SHIFT_W-1:0]       shift_amt,
  input  logic                                relu_en,
  output logic                                Acc_Rd_en,
  output logic        [ACC_ADDR_W-1:0]        Acc_Rd_Addr,
  input  logic signed [PARTIAL_SUM_WIDTH-1:0] Partial_Sum_out,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic signed [OUT_WIDTH-1:0]         out_data,
  output logic        [ACC_ADDR_W-1:0]        out_addr,
  output logic                                busy,
  output logic                                done
);

  localparam logic [ACC_ADDR_W-1:0] LAST_ADDR = ACC_ADDR_W'(DEPTH - 1);

  acc_state_t                  state;
  logic [ACC_ADDR_W-1:0]       rd_ptr;
  logic [ACC_ADDR_W-1:0]       last_addr;
  logic [ACC_SHIFT_W-1:0]      shift_q;
  logic                        relu_q;

  logic                        vld_p1;
  logic [ACC_ADDR_W-1:0]       addr_p1;
  logic signed [OUT_WIDTH-1:0] data_p1;

  logic signed [OUT_WIDTH-1:0] fifo_data [2];
  logic [ACC_ADDR_W-1:0]       fifo_addr [2];
  logic                        wr_sel;
  logic                        rd_sel;
  logic [1:0]                  occ;
  logic [1:0]                  occ_nxt;
  logic [2:0]                  commit;
  logic                        push;
  logic                        pop;

  assign pop     = out_valid & out_ready;
  assign push    = vld_p1;
  assign occ_nxt = occ + {1'b0, push} - {1'b0, pop};

  // Words already owed to the FIFO after this cycle's pop; a new read is only
  // safe when one slot remains for it no matter what out_ready does next cycle.
  assign commit    = {1'b0, occ} + {2'b0, vld_p1} - {2'b0, pop};
  assign Acc_Rd_en = (state == S_READ) && (commit < 3'd2);

  // Address shows the word being read, otherwise holds the last one issued.
  assign Acc_Rd_Addr = Acc_Rd_en ? rd_ptr : last_addr;

  assign out_valid = (occ != 2'd0);
  assign out_data  = fifo_data[rd_sel];
  assign out_addr  = fifo_addr[rd_sel];

  // Control FSM: accept start, issue reads, wait for the FIFO to empty, pulse done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rd_ptr    <= '0;
      last_addr <= '0;
      shift_q   <= '0;
      relu_q    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state   <= S_READ;
            busy    <= 1'b1;
            rd_ptr  <= '0;
            shift_q <= shift_amt;
            relu_q  <= relu_en;
          end
        end
        S_READ: begin
          if (Acc_Rd_en) begin
            last_addr <= rd_ptr;
            if (rd_ptr == LAST_ADDR) begin
              state  <= S_DRAIN;
              rd_ptr <= '0;
            end else begin
              rd_ptr <= rd_ptr + 3'd1;
            end
          end
        end
        S_DRAIN: begin
          if ((occ_nxt == 2'd0) && !vld_p1) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // ---- stage p1: read data returns one cycle after the strobe ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
    end else begin
      vld_p1 <= Acc_Rd_en;
      if (Acc_Rd_en)
        addr_p1 <= Acc_Rd_Addr;
    end
  end

  acc_rd_postproc #(
    .PSW   (PARTIAL_SUM_WIDTH),
    .OUT_W (OUT_WIDTH)
  ) u_postproc (
    .din       (Partial_Sum_out),
    .shift_amt (shift_q),
    .relu_en   (relu_q),
    .dout      (data_p1)
  );

  // ---- stage p2: quantized word and address land in the output FIFO ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_addr[i] <= '0;
      end
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        fifo_data[wr_sel] <= data_p1;
        fifo_addr[wr_sel] <= addr_p1;
        wr_sel            <= ~wr_sel;
      end
      if (pop)
        rd_sel <= ~rd_sel;
      occ <= occ_nxt;
    end
  end

endmodule

// File: doc/acc_readout.md
ACC_READOUT -- requirements
Module: acc_readout

Interface
REQ-001 SHALL have parameter SIZE, default 8: systolic array dimension.
REQ-002 SHALL have parameter DEPTH, default 8: accumulator entries read per drain; addresses 0..DEPTH-1.
REQ-003 SHALL have parameter PARTIAL_SUM_WIDTH, default 8+4+4+$clog2(SIZE) (19): accumulator word width.
REQ-004 SHALL have parameter OUT_WIDTH, default 8: quantized output width.
REQ-005 SHALL have one clock and a synchronous, active-low reset; ports clk and rst_n.
REQ-006 Ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  drain request; sampled only in IDLE.
- shift_amt  in  5  right-shift amount; latched on accepted start.
- relu_en  in  1  ReLU enable; latched on accepted start.
- Acc_Rd_en  out  1  accumulator read strobe.
- Acc_Rd_Addr  out  3  accumulator read address.
- Partial_Sum_out  in  PARTIAL_SUM_WIDTH  signed accumulator read data.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream ready.
- out_data  out  OUT_WIDTH  signed quantized result.
- out_addr  out  3  source address of out_data.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last handshake.

Function
REQ-007 Partial_Sum_out SHALL be treated as valid in the cycle after a cycle with Acc_Rd_en=1, and captured only then.
REQ-008 FSM SHALL have states IDLE, READ, DRAIN, DONE; IDLE->READ on start; READ->DRAIN after read of address DEPTH-1 is issued; DRAIN->DONE once buffer is empty and no read is in flight; DONE->IDLE unconditionally.
REQ-009 start while not IDLE SHALL be ignored.
REQ-010 Reads SHALL be issued in ascending order 0..DEPTH-1, each address exactly once per drain; Acc_Rd_Addr SHALL hold its last value when Acc_Rd_en=0.
REQ-011 A read SHALL be issued in a READ cycle only if occ + inflight - (out_valid & out_ready) < 2, where occ is output-buffer occupancy (0..2) and inflight is 1 if a read was issued in the previous cycle.
REQ-012 Returned data SHALL be post-processed combinationally: arithmetic right shift by shift_amt, plus rounding bit (bit shift_amt-1 of the input) when shift_amt>0, computed at PARTIAL_SUM_WIDTH+1 bits without overflow.
REQ-013 With relu_en=1, negative results SHALL become 0.
REQ-014 Results SHALL saturate to [-128,127] (OUT_WIDTH signed).
REQ-015 Processed word and address SHALL be written to a 2-entry FIFO at the end of the capture cycle; out_valid = FIFO non-empty; out_data/out_addr = FIFO head.
REQ-016 Handshake: transfer when out_valid & out_ready; out_data/out_addr SHALL hold stable while out_valid=1 and out_ready=0.
REQ-017 Simultaneous FIFO push and pop SHALL keep occupancy unchanged; FIFO SHALL never overflow.
REQ-018 Latency: start sampled at edge t -> Acc_Rd_en high in cycle t+1 -> first out_valid in cycle t+3; with out_ready held 1, one word per cycle, no bubbles.
REQ-019 done SHALL pulse one cycle (DONE state); busy SHALL be low in IDLE only.

Reset
REQ-020 rst_n=0 at an edge SHALL force IDLE, empty FIFO, inflight=0, and Acc_Rd_en, out_valid, busy, done, out_data, out_addr, Acc_Rd_Addr to 0, including mid-drain; returned data in flight SHALL be discarded.

Structure
REQ-021 Package acc_pkg SHALL hold SIZE, DEPTH, width constants and the FSM state encoding.
REQ-022 Shift/round/ReLU/saturate SHALL be one combinational sub-module acc_rd_postproc.

Verification (accumulator model: 1-cycle read latency)
REQ-023 mem={256,-300,5000,-5000,0,15,16,-1}, shift 4, relu 0, ready=1 -> out 16,-19,127,-128,0,1,1,0 on addr 0..7, 8 consecutive cycles, done once.
REQ-024 Same mem, relu 1 -> 16,0,127,0,0,1,1,0.
REQ-025 shift 0, mem[i]=i-4 -> -4..3 exactly; no rounding applied.
REQ-026 out_ready toggled randomly -> no loss/duplication/reorder; data stable under stall; Acc_Rd_en never issued with occ+inflight-pop >= 2.
REQ-027 start pulsed while busy -> ignored; exactly 8 outputs.
REQ-028 rst_n low after 3rd output -> next cycle all outputs 0, IDLE; new start yields full 8-word drain from addr 0.
